// File: rtl/branch_pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pc_unit_if
//  Purpose  : Bundles the ID-stage branch/jump request and the next-PC
//             results exchanged with branch_pc_unit.
//  Modports : master - ID-stage side; drives the request, observes results.
//             slave  - branch_pc_unit side; consumes the request, drives
//                      pc/taken/flush/link/taken_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_pc_unit_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             stall;
   logic             br_valid;
   logic [5:0]       opcode;
   logic [4:0]       rt_field;
   logic [5:0]       funct;
   logic [WIDTH-1:0] br_pc;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic [15:0]      imm16;
   logic [25:0]      target26;
   logic [WIDTH-1:0] pc;
   logic             taken;
   logic             flush;
   logic             link_we;
   logic [WIDTH-1:0] link_addr;
   logic [CNT_W-1:0] taken_cnt;

   modport master (
      output stall, br_valid, opcode, rt_field, funct, br_pc,
             rs_data, rt_data, imm16, target26,
      input  pc, taken, flush, link_we, link_addr, taken_cnt
   );

   modport slave (
      input  stall, br_valid, opcode, rt_field, funct, br_pc,
             rs_data, rt_data, imm16, target26,
      output pc, taken, flush, link_we, link_addr, taken_cnt
   );
endinterface
`default_nettype wire

// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pc_unit
//  Purpose  : Next-PC generator for the MIPS core. Owns the fetch PC,
//             resolves beq/bne/blez/bgtz, REGIMM bltz/bgez/bltzal/bgezal,
//             j/jal and jr/jalr internally, buffers a redirect that arrives
//             while fetch is stalled, and counts applied redirects.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - branch_pc_unit_if.slave (request in, pc/taken/flush/
//                     link_we/link_addr/taken_cnt out)
//  Revision : 1.0 - initial release
// ============================================================================
module branch_pc_unit #(
   parameter int          WIDTH      = 32,
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter bit          DELAY_SLOT = 1'b1,
   parameter int          CNT_W      = 16
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   branch_pc_unit_if.slave  bus
);

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;
   localparam logic [4:0] RI_BLTZ    = 5'b00000;
   localparam logic [4:0] RI_BGEZ    = 5'b00001;
   localparam logic [4:0] RI_BLTZAL  = 5'b10000;
   localparam logic [4:0] RI_BGEZAL  = 5'b10001;

   localparam logic [WIDTH-1:0] PC_RESET = WIDTH'(RESET_PC);
   localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);
   localparam logic [WIDTH-1:0] LINK_OFF = DELAY_SLOT ? WIDTH'(8) : WIDTH'(4);

   typedef enum logic [0:0] {
      S_IDLE    = 1'b0,
      S_PENDING = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_pend_target;
   logic             r_flush;
   logic [CNT_W-1:0] r_taken_cnt;

   logic [WIDTH-1:0] w_pc4;
   logic [WIDTH-1:0] w_br_off;
   logic [WIDTH-1:0] w_br_target;
   logic [WIDTH-1:0] w_j_target;
   logic [WIDTH-1:0] w_target;
   logic             w_cond;
   logic             w_link;
   logic             w_taken;
   logic             w_rs_neg;
   logic             w_rs_zero;
   logic [CNT_W-1:0] w_cnt_next;

   // Signed tests on rs reduce to its sign bit and a zero detect.
   assign w_rs_neg    = bus.rs_data[WIDTH-1];
   assign w_rs_zero   = (bus.rs_data == '0);

   assign w_pc4       = bus.br_pc + PC_STEP;
   assign w_br_off    = {{(WIDTH-18){bus.imm16[15]}}, bus.imm16, 2'b00};
   assign w_br_target = w_pc4 + w_br_off;
   assign w_j_target  = {w_pc4[WIDTH-1:28], bus.target26, 2'b00};

   always_comb begin
      w_cond   = 1'b0;
      w_link   = 1'b0;
      w_target = w_br_target;
      case (bus.opcode)
         OP_SPECIAL: begin
            w_target = bus.rs_data;
            if (bus.funct == FN_JR) begin
               w_cond = 1'b1;
            end else if (bus.funct == FN_JALR) begin
               w_cond = 1'b1;
               w_link = 1'b1;
            end
         end
         OP_REGIMM: begin
            case (bus.rt_field)
               RI_BLTZ:   w_cond = w_rs_neg;
               RI_BGEZ:   w_cond = ~w_rs_neg;
               RI_BLTZAL: begin
                  w_cond = w_rs_neg;
                  w_link = 1'b1;
               end
               RI_BGEZAL: begin
                  w_cond = ~w_rs_neg;
                  w_link = 1'b1;
               end
               default:   w_cond = 1'b0;
            endcase
         end
         OP_J: begin
            w_cond   = 1'b1;
            w_target = w_j_target;
         end
         OP_JAL: begin
            w_cond   = 1'b1;
            w_link   = 1'b1;
            w_target = w_j_target;
         end
         OP_BEQ:  w_cond = (bus.rs_data == bus.rt_data);
         OP_BNE:  w_cond = (bus.rs_data != bus.rt_data);
         OP_BLEZ: w_cond = w_rs_neg | w_rs_zero;
         OP_BGTZ: w_cond = ~w_rs_neg & ~w_rs_zero;
         default: w_cond = 1'b0;
      endcase
   end

   // While a redirect is pending, the stalled ID instruction is the one
   // already captured, so its request must not be resolved a second time.
   assign w_taken    = (r_state == S_IDLE) && bus.br_valid && w_cond;

   assign w_cnt_next = (&r_taken_cnt) ? r_taken_cnt : r_taken_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_pc          <= PC_RESET;
         r_pend_target <= '0;
         r_flush       <= 1'b0;
         r_taken_cnt   <= '0;
      end else begin
         r_flush <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!bus.stall) begin
                  if (w_taken) begin
                     r_pc        <= w_target;
                     r_taken_cnt <= w_cnt_next;
                     r_flush     <= !DELAY_SLOT;
                  end else begin
                     r_pc <= r_pc + PC_STEP;
                  end
               end else if (w_taken) begin
                  r_pend_target <= w_target;
                  r_state       <= S_PENDING;
               end
            end
            S_PENDING: begin
               if (!bus.stall) begin
                  r_pc        <= r_pend_target;
                  r_taken_cnt <= w_cnt_next;
                  r_flush     <= !DELAY_SLOT;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.pc        = r_pc;
   assign bus.taken     = w_taken;
   assign bus.flush     = r_flush;
   assign bus.link_we   = bus.br_valid && w_link;
   assign bus.link_addr = bus.br_pc + LINK_OFF;
   assign bus.taken_cnt = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_pc_unit
//  Purpose  : Directed self-checking bench for branch_pc_unit. Instance A
//             uses the delay-slot build (CNT_W=16); instance B uses the
//             flush build with a 4-bit saturating counter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_pc_unit;

   logic clk = 1'b0;
   logic rst_a_n;
   logic rst_b_n;
   int   checks = 0;
   int   errors = 0;

   logic [63:0] sb_q[$];

   always #5 clk = ~clk;

   branch_pc_unit_if #(.WIDTH(32), .CNT_W(16)) bus_a ();
   branch_pc_unit_if #(.WIDTH(32), .CNT_W(4))  bus_b ();

   branch_pc_unit #(
      .WIDTH(32), .RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b1), .CNT_W(16)
   ) u_dut_a (
      .clk   (clk),
      .rst_n (rst_a_n),
      .bus   (bus_a)
   );

   branch_pc_unit #(
      .WIDTH(32), .RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b0), .CNT_W(4)
   ) u_dut_b (
      .clk   (clk),
      .rst_n (rst_b_n),
      .bus   (bus_b)
   );

   task automatic push(input logic [63:0] e);
      sb_q.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs);
      logic [63:0] e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty, observed=%0h", tag, obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [5:0] op, input logic [4:0] rtf,
                          input logic [5:0] fn, input logic [31:0] bpc,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [15:0] imm, input logic [25:0] t26);
      bus_a.br_valid = v;   bus_a.opcode  = op;  bus_a.rt_field = rtf;
      bus_a.funct    = fn;  bus_a.br_pc   = bpc; bus_a.rs_data  = rs;
      bus_a.rt_data  = rt;  bus_a.imm16   = imm; bus_a.target26 = t26;
   endtask

   task automatic drive_b(input logic v, input logic [5:0] op,
                          input logic [31:0] bpc, input logic [25:0] t26);
      bus_b.br_valid = v;   bus_b.opcode  = op;    bus_b.rt_field = 5'd0;
      bus_b.funct    = 6'd0; bus_b.br_pc  = bpc;   bus_b.rs_data  = 32'd0;
      bus_b.rt_data  = 32'd0; bus_b.imm16 = 16'd0; bus_b.target26 = t26;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      bus_a.stall = 1'b0;
      bus_b.stall = 1'b1;
      drive_a(1'b0, 6'h3f, 5'd0, 6'd0, 32'd0, 32'd0, 32'd0, 16'd0, 26'd0);
      drive_b(1'b0, 6'h3f, 32'd0, 26'd0);
      #12;
      // Reset state
      push(64'h3000); chk("a_reset_pc", bus_a.pc);
      push(64'h0);    chk("a_reset_cnt", bus_a.taken_cnt);
      push(64'h0);    chk("a_reset_flush", bus_a.flush);
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;

      // Free run
      push(64'h3004); tick(); chk("a_run1_pc", bus_a.pc);
      push(64'h3008); tick(); chk("a_run2_pc", bus_a.pc);
      push(64'h0);    chk("a_run_cnt", bus_a.taken_cnt);
      push(64'h0);    chk("a_run_flush", bus_a.flush);

      // beq taken: 0x3004+4-8 = 0x3000
      drive_a(1'b1, 6'b000100, 5'd0, 6'd0, 32'h3004, 32'd5, 32'd5, 16'hFFFE, 26'd0);
      #1;
      push(64'h1); chk("a_beq_taken", bus_a.taken);
      push(64'h0); chk("a_beq_link_we", bus_a.link_we);
      push(64'h3000); tick(); chk("a_beq_pc", bus_a.pc);
      push(64'h1);    chk("a_beq_cnt", bus_a.taken_cnt);

      // beq not taken
      drive_a(1'b1, 6'b000100, 5'd0, 6'd0, 32'h3004, 32'd5, 32'd6, 16'hFFFE, 26'd0);
      #1;
      push(64'h0); chk("a_beq_nt_taken", bus_a.taken);
      push(64'h3004); tick(); chk("a_beq_nt_pc", bus_a.pc);

      // bgezal with negative rs: not taken but still links
      drive_a(1'b1, 6'b000001, 5'b10001, 6'd0, 32'h3010, 32'hFFFF_FFFF, 32'd0, 16'h0010, 26'd0);
      #1;
      push(64'h0);    chk("a_bgezal_taken", bus_a.taken);
      push(64'h1);    chk("a_bgezal_link_we", bus_a.link_we);
      push(64'h3018); chk("a_bgezal_link_addr", bus_a.link_addr);
      push(64'h3008); tick(); chk("a_bgezal_pc", bus_a.pc);

      // bltzal with negative rs: taken, target 0x3014+0x40
      drive_a(1'b1, 6'b000001, 5'b10000, 6'd0, 32'h3010, 32'hFFFF_FFFF, 32'd0, 16'h0010, 26'd0);
      #1;
      push(64'h1); chk("a_bltzal_taken", bus_a.taken);
      push(64'h3054); tick(); chk("a_bltzal_pc", bus_a.pc);

      // blez with rs=0 is taken (boundary)
      drive_a(1'b1, 6'b000110, 5'd0, 6'd0, 32'h3100, 32'd0, 32'd0, 16'h0010, 26'd0);
      #1;
      push(64'h1); chk("a_blez0_taken", bus_a.taken);
      push(64'h3144); tick(); chk("a_blez0_pc", bus_a.pc);

      // bgtz with rs=0 is not taken (boundary)
      drive_a(1'b1, 6'b000111, 5'd0, 6'd0, 32'h3100, 32'd0, 32'd0, 16'h0010, 26'd0);
      #1;
      push(64'h0); chk("a_bgtz0_taken", bus_a.taken);
      push(64'h3148); tick(); chk("a_bgtz0_pc", bus_a.pc);
      push(64'h3);    chk("a_cnt_after_br", bus_a.taken_cnt);

      // jal keeps the upper nibble of br_pc+4
      drive_a(1'b1, 6'b000011, 5'd0, 6'd0, 32'h1000_0000, 32'd0, 32'd0, 16'd0, 26'h0000040);
      #1;
      push(64'h1);         chk("a_jal_link_we", bus_a.link_we);
      push(64'h1000_0008); chk("a_jal_link_addr", bus_a.link_addr);
      push(64'h1000_0100); tick(); chk("a_jal_pc", bus_a.pc);
      push(64'h4);         chk("a_jal_cnt", bus_a.taken_cnt);

      // jr during a 3-cycle stall, br_valid held high throughout
      bus_a.stall = 1'b1;
      drive_a(1'b1, 6'b000000, 5'd0, 6'b001000, 32'h2000, 32'h0040_0000, 32'd0, 16'd0, 26'd0);
      #1;
      push(64'h1); chk("a_jr_stall_taken", bus_a.taken);
      for (int i = 0; i < 3; i++) begin
         tick();
         push(64'h1000_0100); chk("a_jr_stall_pc", bus_a.pc);
         push(64'h4);         chk("a_jr_stall_cnt", bus_a.taken_cnt);
         push(64'h0);         chk("a_jr_pending_taken", bus_a.taken);
      end
      bus_a.stall = 1'b0;
      push(64'h0040_0000); tick(); chk("a_jr_release_pc", bus_a.pc);
      push(64'h5);         chk("a_jr_release_cnt", bus_a.taken_cnt);
      bus_a.br_valid = 1'b0;
      push(64'h0040_0004); tick(); chk("a_jr_after_pc", bus_a.pc);
      push(64'h5);         chk("a_jr_after_cnt", bus_a.taken_cnt);

      // jalr to the top of the address space, then pc+4 wraps to 0
      drive_a(1'b1, 6'b000000, 5'd0, 6'b001001, 32'h2000, 32'hFFFF_FFFC, 32'd0, 16'd0, 26'd0);
      #1;
      push(64'h1);    chk("a_jalr_link_we", bus_a.link_we);
      push(64'h2008); chk("a_jalr_link_addr", bus_a.link_addr);
      push(64'hFFFF_FFFC); tick(); chk("a_jalr_pc", bus_a.pc);
      bus_a.br_valid = 1'b0;
      push(64'h0); tick(); chk("a_wrap_pc", bus_a.pc);

      // Misaligned jr target passes through
      drive_a(1'b1, 6'b000000, 5'd0, 6'b001000, 32'h2000, 32'h0000_1003, 32'd0, 16'd0, 26'd0);
      push(64'h1003); tick(); chk("a_jr_misaligned_pc", bus_a.pc);
      bus_a.br_valid = 1'b0;

      // Instance B: no delay slot, j then one-cycle flush
      bus_b.stall = 1'b0;
      drive_b(1'b1, 6'b000010, 32'h3000, 26'h0000100);
      #1;
      push(64'h1);    chk("b_j_taken", bus_b.taken);
      push(64'h3004); chk("b_link_addr", bus_b.link_addr);
      push(64'h0);    chk("b_pre_flush", bus_b.flush);
      push(64'h400);  tick(); chk("b_j_pc", bus_b.pc);
      push(64'h1);    chk("b_flush_on", bus_b.flush);
      bus_b.br_valid = 1'b0;
      push(64'h404);  tick(); chk("b_after_pc", bus_b.pc);
      push(64'h0);    chk("b_flush_off", bus_b.flush);
      push(64'h1);    chk("b_cnt1", bus_b.taken_cnt);

      // 16 more redirects: counter must stop at 0xF
      drive_b(1'b1, 6'b000010, 32'h3000, 26'h0000100);
      for (int i = 0; i < 16; i++) begin
         tick();
         push((i + 2 > 15) ? 64'hF : 64'(i + 2));
         chk("b_sat_cnt", bus_b.taken_cnt);
      end
      push(64'h400); chk("b_sat_pc", bus_b.pc);

      // Enter PENDING, then reset before the redirect is applied
      bus_b.stall = 1'b1;
      drive_b(1'b1, 6'b000010, 32'h3000, 26'h0000200);
      tick();
      push(64'h400); chk("b_pending_pc", bus_b.pc);
      rst_b_n = 1'b0;
      #1;
      push(64'h3000); chk("b_async_rst_pc", bus_b.pc);
      push(64'h0);    chk("b_async_rst_cnt", bus_b.taken_cnt);
      push(64'h0);    chk("b_async_rst_flush", bus_b.flush);
      bus_b.stall = 1'b0;
      bus_b.br_valid = 1'b0;
      #2;
      rst_b_n = 1'b1;
      push(64'h3004); tick(); chk("b_post_rst_pc1", bus_b.pc);
      push(64'h3008); tick(); chk("b_post_rst_pc2", bus_b.pc);
      push(64'h0);    chk("b_post_rst_cnt", bus_b.taken_cnt);
      push(64'h0);    chk("b_post_rst_flush", bus_b.flush);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
